// File: rtl/grid_pkg.sv
// Shared types and helpers for the 8x8 Life grid datapath.
// Contents: grid geometry constants, grid/row types, loader state enum,
//           and a row-insertion helper used when assembling a frame.
package grid_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;

  typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;
  typedef logic [GRID_COLS-1:0]           row_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD
  } loader_state_t;

  // Return g with row idx replaced by r; row 0 lives in the top byte.
  function automatic grid_t put_row(grid_t g, row_t r, logic [2:0] idx);
    grid_t res;
    res = g;
    for (int i = 0; i < GRID_ROWS; i++) begin
      if (idx == 3'(i)) begin
        res[(GRID_ROWS-1-i)*GRID_COLS +: GRID_COLS] = r;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/grid_seed_loader.sv
// Purpose: assembles one 8x8 grid frame from a byte stream and hands it off as a 64-bit seed.
// Latency: seed/seed_valid appear the cycle after the final beat; err the cycle after the bad beat.
// Backpressure: in_ready low only while a finished seed waits for seed_ack; no byte is taken then.
//
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data/in_last byte stream in;
//        seed/seed_valid/seed_ack frame handoff out; err framing/checksum error flag.
// Parameter ERR_STICKY: 0 = one-cycle err pulse, 1 = err held until the next frame's first beat.
// Optional macro GRID_SEED_CHECKSUM_EN: 9-byte frames whose last byte is the XOR of the 8 rows.
module grid_seed_loader
  import grid_pkg::*;
#(
  parameter bit ERR_STICKY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [63:0] seed,
  output logic        seed_valid,
  input  logic        seed_ack,
  output logic        err
);

`ifdef GRID_SEED_CHECKSUM_EN
  localparam int          CNT_W  = 4;
  localparam logic [3:0]  LAST_K = 4'd8;   // checksum beat
`else
  localparam int          CNT_W  = 3;
  localparam logic [2:0]  LAST_K = 3'd7;   // row 7 beat
`endif

  loader_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  grid_t            shadow, shadow_nxt;
  grid_t            seed_nxt;
  logic             err_evt;
  logic             beat;
  logic             idle_beat;

`ifdef GRID_SEED_CHECKSUM_EN
  row_t             csum, csum_nxt;
`endif

  assign in_ready   = (state != HOLD);
  assign seed_valid = (state == HOLD);
  assign beat       = in_valid && in_ready;
  assign idle_beat  = beat && (state == IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    seed_nxt   = seed;
    err_evt    = 1'b0;
`ifdef GRID_SEED_CHECKSUM_EN
    csum_nxt   = csum;
`endif
    case (state)
      IDLE, LOAD: begin
        if (beat) begin
          if (cnt == LAST_K) begin
            // Frame-ending beat: every outcome restarts the row count.
            cnt_nxt    = '0;
            shadow_nxt = '0;
`ifdef GRID_SEED_CHECKSUM_EN
            csum_nxt   = '0;
            if (!in_last) begin
              err_evt   = 1'b1;
              state_nxt = DRAIN;
            end else if (in_data == csum) begin
              seed_nxt  = shadow;
              state_nxt = HOLD;
            end else begin
              err_evt   = 1'b1;
              state_nxt = IDLE;
            end
`else
            if (in_last) begin
              seed_nxt  = put_row(shadow, in_data, 3'd7);
              state_nxt = HOLD;
            end else begin
              err_evt   = 1'b1;
              state_nxt = DRAIN;
            end
`endif
          end else if (in_last) begin
            // Frame ended early: drop the partial rows.
            err_evt    = 1'b1;
            cnt_nxt    = '0;
            shadow_nxt = '0;
            state_nxt  = IDLE;
`ifdef GRID_SEED_CHECKSUM_EN
            csum_nxt   = '0;
`endif
          end else begin
            shadow_nxt = put_row(shadow, in_data, cnt[2:0]);
            cnt_nxt    = cnt + 1'b1;
            state_nxt  = LOAD;
`ifdef GRID_SEED_CHECKSUM_EN
            csum_nxt   = csum ^ in_data;
`endif
          end
        end
      end
      DRAIN: begin
        if (beat && in_last) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (seed_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      seed   <= '0;
      err    <= 1'b0;
`ifdef GRID_SEED_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      seed   <= seed_nxt;
      // A new error wins over the clearing first beat that raised it.
      if (ERR_STICKY) begin
        err <= err_evt | (err & ~idle_beat);
      end else begin
        err <= err_evt;
      end
`ifdef GRID_SEED_CHECKSUM_EN
      csum   <= csum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_grid_seed_loader.sv
module tb_grid_seed_loader;

`ifdef GRID_SEED_CHECKSUM_EN
  localparam int ERR_BEAT = 9;
`else
  localparam int ERR_BEAT = 8;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [63:0] seed;
  logic        seed_valid;
  logic        seed_ack;
  logic        err;

  logic        in_ready_s;
  logic [63:0] seed_s;
  logic        seed_valid_s;
  logic        err_s;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  grid_seed_loader #(.ERR_STICKY(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ack   (seed_ack),
    .err        (err)
  );

  grid_seed_loader #(.ERR_STICKY(1'b1)) dut_sticky (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready_s),
    .in_data    (in_data),
    .in_last    (in_last),
    .seed       (seed_s),
    .seed_valid (seed_valid_s),
    .seed_ack   (seed_ack),
    .err        (err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the beat edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f);
    logic [7:0] x;
    logic       lst;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      lst = (i == 7);
`ifdef GRID_SEED_CHECKSUM_EN
      lst = 1'b0;
`endif
      x = x ^ f[56-8*i +: 8];
      send_byte(f[56-8*i +: 8], lst);
    end
`ifdef GRID_SEED_CHECKSUM_EN
    send_byte(x, 1'b1);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    seed_ack = 1'b0;

    // Reset state
    #2;
    check("rst_seed", seed, 64'h0);
    check("rst_seed_valid", {63'b0, seed_valid}, 64'h0);
    check("rst_err", {63'b0, err}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'h1);
    tick();

    // Basic frame, ack a few cycles later
    send_frame(64'h0405060000000000);
    check("f1_seed", seed, 64'h0405060000000000);
    check("f1_valid", {63'b0, seed_valid}, 64'h1);
    check("f1_ready", {63'b0, in_ready}, 64'h0);
    check("f1_err", {63'b0, err}, 64'h0);
    tick();
    tick();
    check("f1_valid_hold", {63'b0, seed_valid}, 64'h1);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    check("f1_valid_drop", {63'b0, seed_valid}, 64'h0);
    check("f1_ready_back", {63'b0, in_ready}, 64'h1);

    // All-ones frame, then a short frame
    send_frame(64'hFFFFFFFFFFFFFFFF);
    check("f2_seed", seed, 64'hFFFFFFFFFFFFFFFF);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check("short_err", {63'b0, err}, 64'h1);
    check("short_err_sticky", {63'b0, err_s}, 64'h1);
    check("short_seed", seed, 64'hFFFFFFFFFFFFFFFF);
    check("short_valid", {63'b0, seed_valid}, 64'h0);
    check("short_ready", {63'b0, in_ready}, 64'h1);
    seed_ack = 1'b1;   // ignored outside HOLD
    tick();
    seed_ack = 1'b0;
    check("short_err_pulse", {63'b0, err}, 64'h0);
    check("short_sticky_held", {63'b0, err_s}, 64'h1);
    check("idle_ack_ignored", {63'b0, seed_valid}, 64'h0);

    // Overlong frame: error at the frame-ending beat, rest drained
    for (int i = 1; i <= 11; i++) begin
      send_byte(8'(i), i == 11);
      if (i == 1) check("sticky_clear", {63'b0, err_s}, 64'h0);
      if (i == ERR_BEAT - 1) check("long_no_err_yet", {63'b0, err}, 64'h0);
      if (i == ERR_BEAT) check("long_err", {63'b0, err}, 64'h1);
      if (i == ERR_BEAT + 1) check("long_err_pulse", {63'b0, err}, 64'h0);
    end
    check("long_seed", seed, 64'hFFFFFFFFFFFFFFFF);
    check("long_valid", {63'b0, seed_valid}, 64'h0);
    check("long_err_end", {63'b0, err}, 64'h0);
    check("long_ready", {63'b0, in_ready}, 64'h1);

    // Backpressure in HOLD
    send_frame(64'h0102030405060708);
    check("bp_seed", seed, 64'h0102030405060708);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_ready", {63'b0, in_ready}, 64'h0);
      check("bp_seed_stable", seed, 64'h0102030405060708);
    end
    in_valid = 1'b0;
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    check("bp_released", {63'b0, seed_valid}, 64'h0);
    send_frame(64'h1122334455667788);
    check("bp_next_seed", seed, 64'h1122334455667788);
    check("bp_next_valid", {63'b0, seed_valid}, 64'h1);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b0);
    reset = 1'b1;
    #1;
    check("mrst_seed", seed, 64'h0);
    check("mrst_valid", {63'b0, seed_valid}, 64'h0);
    check("mrst_err", {63'b0, err}, 64'h0);
    check("mrst_ready", {63'b0, in_ready}, 64'h1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    send_frame(64'hA0A1A2A3A4A5A6A7);
    check("mrst_frame_seed", seed, 64'hA0A1A2A3A4A5A6A7);
    check("mrst_frame_valid", {63'b0, seed_valid}, 64'h1);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;

`ifdef GRID_SEED_CHECKSUM_EN
    // Checksum good and bad
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h40, 1'b0); send_byte(8'h80, 1'b0);
    check("cs_no_valid_before_cs", {63'b0, seed_valid}, 64'h0);
    send_byte(8'hFF, 1'b1);
    check("cs_good_seed", seed, 64'h0102040810204080);
    check("cs_good_valid", {63'b0, seed_valid}, 64'h1);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h40, 1'b0); send_byte(8'h80, 1'b0);
    send_byte(8'hFE, 1'b1);
    check("cs_bad_err", {63'b0, err}, 64'h1);
    check("cs_bad_seed", seed, 64'h0102040810204080);
    check("cs_bad_valid", {63'b0, seed_valid}, 64'h0);
    tick();
    check("cs_bad_err_pulse", {63'b0, err}, 64'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
